// File: rtl/axil_gpio_pkg.sv
// Shared types for the AXI4-Lite GPIO register block.
// Contents: AXI response codes, write/read FSM state enums, register kind decode helper.
package axil_gpio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;

  typedef enum logic [1:0] {KIND_OUT, KIND_IN, KIND_PULSE, KIND_NONE} reg_kind_t;

  // Word index -> register kind. OUT regs first, then IN regs, then the single PULSE reg.
  function automatic reg_kind_t reg_kind(input logic [31:0] idx, input int unsigned n_out,
                                         input int unsigned n_in);
    if (idx < n_out) return KIND_OUT;
    if (idx < n_out + n_in) return KIND_IN;
    if (idx == n_out + n_in) return KIND_PULSE;
    return KIND_NONE;
  endfunction

endpackage

// File: rtl/axil_gpio_regs_if.sv
// AXI4-Lite bus bundle for the GPIO register block (32-bit data).
// master: drives AW/W/AR channels and B/R ready; slave: drives the rest.
interface axil_gpio_regs_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/gpio_in_sync.sv
// Per-bit flop-chain synchroniser for asynchronous GPIO inputs.
// Ports: clk, resetn (sync, active-low), d_i (async in), q_o (d_i delayed STAGES cycles).
// STAGES = 0 gives a plain wire. Bits are independent; no multi-bit coherency.
module gpio_in_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ resetn;
    assign q_o = d_i;
  end else begin : g_sync
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/axil_gpio_regs.sv
// AXI4-Lite GPIO / control register slave.
// Map by word index: [0, N_OUT) RW OUT regs, [N_OUT, N_OUT+N_IN) RO synchronised IN regs,
// N_OUT+N_IN write-1-to-pulse reg (reads 0); everything else DECERR.
// Ports: clk, resetn (sync, active-low), s_axil (AXI4-Lite slave), gpio_out_o (OUT regs,
// reg k at [32k+31:32k]), gpio_in_i (async inputs), pulse_out_o (one-cycle strobes).
module axil_gpio_regs
  import axil_gpio_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned N_IN        = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int unsigned SYNC_STAGES = 2,
  // Keeps the input port non-empty when N_IN = 0.
  localparam int unsigned InW        = (N_IN == 0) ? 32 : N_IN * 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  axil_gpio_regs_if.slave       s_axil,
  output logic [N_OUT*32-1:0]   gpio_out_o,
  input  logic [InW-1:0]        gpio_in_i,
  output logic [31:0]           pulse_out_o
);

  logic [InW-1:0] in_sync;

  gpio_in_sync #(
    .WIDTH  (InW),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (gpio_in_i),
    .q_o    (in_sync)
  );

  // Address bits [1:0] carry no information for word registers.
  logic unused_addr;
  assign unused_addr = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

  // ---------------- write channel ----------------
  w_state_t               w_state_q, w_state_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [N_OUT-1:0][31:0] out_q, out_d;
  logic [31:0]            pulse_q, pulse_d;
  logic [31:0]            w_idx, wmask;
  reg_kind_t              w_kind;

  assign w_idx  = 32'(s_axil.awaddr[ADDR_WIDTH-1:2]);
  assign w_kind = reg_kind(w_idx, N_OUT, N_IN);

  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{s_axil.wstrb[b]}};
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    out_d     = out_q;
    pulse_d   = '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axil.awvalid && s_axil.wvalid) w_state_d = W_ACK;
      end
      W_ACK: begin
        // Address/data are taken on this cycle's closing edge, together with the commit.
        w_state_d = W_RESP;
        unique case (w_kind)
          KIND_OUT: begin
            bresp_d = RESP_OKAY;
            for (int unsigned k = 0; k < N_OUT; k++) begin
              if (w_idx == k) out_d[k] = (out_q[k] & ~wmask) | (s_axil.wdata & wmask);
            end
          end
          KIND_IN: bresp_d = RESP_SLVERR;
          KIND_PULSE: begin
            bresp_d = RESP_OKAY;
            pulse_d = s_axil.wdata & wmask;
          end
          default: bresp_d = RESP_DECERR;
        endcase
      end
      W_RESP: begin
        if (s_axil.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      bresp_q   <= '0;
      out_q     <= {N_OUT{OUT_RESET}};
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      bresp_q   <= bresp_d;
      out_q     <= out_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s_axil.awready = (w_state_q == W_ACK);
  assign s_axil.wready  = (w_state_q == W_ACK);
  assign s_axil.bvalid  = (w_state_q == W_RESP);
  assign s_axil.bresp   = bresp_q;
  assign gpio_out_o     = out_q;
  assign pulse_out_o    = pulse_q;

  // ---------------- read channel ----------------
  r_state_t    r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] r_idx;
  reg_kind_t   r_kind;

  assign r_idx  = 32'(s_axil.araddr[ADDR_WIDTH-1:2]);
  assign r_kind = reg_kind(r_idx, N_OUT, N_IN);

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axil.arvalid) r_state_d = R_ACK;
      end
      R_ACK: begin
        // Captured from out_q (not out_d), so a same-edge write returns the old value.
        r_state_d = R_RESP;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        unique case (r_kind)
          KIND_OUT: begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              if (r_idx == k) rdata_d = out_q[k];
            end
          end
          KIND_IN: begin
            for (int unsigned j = 0; j < N_IN; j++) begin
              if (r_idx == N_OUT + j) rdata_d = in_sync[32*j +: 32];
            end
          end
          KIND_PULSE: rdata_d = '0;
          default: rresp_d = RESP_DECERR;
        endcase
      end
      R_RESP: begin
        if (s_axil.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil.arready = (r_state_q == R_ACK);
  assign s_axil.rvalid  = (r_state_q == R_RESP);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed bench for axil_gpio_regs: N_OUT=2, N_IN=2, OUT_RESET=5, SYNC_STAGES=2.
// Map: 0x00 OUT0, 0x04 OUT1, 0x08 IN0, 0x0C IN1, 0x10 PULSE, rest DECERR.
module tb_axil_gpio_regs;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] gpio_out;
  logic [63:0] gpio_in;
  logic [31:0] pulse_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_gpio_regs_if #(.ADDR_WIDTH(8)) bus ();

  axil_gpio_regs #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (32),
    .N_OUT       (2),
    .N_IN        (2),
    .OUT_RESET   (32'h5),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_axil      (bus),
    .gpio_out_o  (gpio_out),
    .gpio_in_i   (gpio_in),
    .pulse_out_o (pulse_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full write with bready high; returns bresp, cycles to awready and pulse_out at bvalid.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output int lat, output logic [31:0] pulse);
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.awready && lat < 20);
    check("w_ready", {62'b0, bus.awready, bus.wready}, 64'd3);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("b_valid", bus.bvalid, 1);
    resp  = bus.bresp;
    pulse = pulse_out;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
    check("ar_ready", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("r_valid", bus.rvalid, 1);
    data = bus.rdata;
    resp = bus.rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, pl;
    int          lat, n;
    logic        seen;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 1; bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
    gpio_in = '0;
    resetn  = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", gpio_out, 64'h00000005_00000005);
    check("rst_hs", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
    check("rst_misc", {pulse_out, bus.rdata}, 0);
    check("rst_resp", {bus.bresp, bus.rresp}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // OUT[1] write/read, with latency
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, resp, lat, pl);
    check("out1_lat", lat, 2);
    check("out1_resp", resp, 2'b00);
    check("out1_val", gpio_out, 64'hDEADBEEF_00000005);
    axi_read(8'h04, rd, resp);
    check("out1_rd", rd, 32'hDEADBEEF);
    check("out1_rresp", resp, 2'b00);

    // Byte strobes
    axi_write(8'h00, 32'h11223344, 4'hF, resp, lat, pl);
    axi_write(8'h00, 32'hAABBCCDD, 4'b0101, resp, lat, pl);
    check("strb_val", gpio_out[31:0], 32'h11BB33DD);
    axi_write(8'h00, 32'hFFFFFFFF, 4'h0, resp, lat, pl);
    check("strb0_resp", resp, 2'b00);
    axi_read(8'h00, rd, resp);
    check("strb0_rd", rd, 32'h11BB33DD);

    // Input path
    gpio_in = {32'h0, 32'hCAFE0001};
    repeat (3) @(posedge clk);
    axi_read(8'h08, rd, resp);
    check("in0_rd", rd, 32'hCAFE0001);
    check("in0_rresp", resp, 2'b00);
    axi_write(8'h08, 32'h0, 4'hF, resp, lat, pl);
    check("in0_wresp", resp, 2'b10);
    axi_read(8'h08, rd, resp);
    check("in0_rd2", rd, 32'hCAFE0001);
    check("in0_out", gpio_out, 64'hDEADBEEF_11BB33DD);

    // Two-stage latency: a change presented with arvalid is not yet visible
    @(posedge clk); #1;
    gpio_in[63:32] = 32'h12345678;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("sync_lat", {bus.rvalid, bus.rdata}, {1'b1, 32'h0});
    @(posedge clk); #1;
    axi_read(8'h0C, rd, resp);
    check("in1_rd", rd, 32'h12345678);

    // Pulse register
    axi_write(8'h10, 32'h3, 4'hF, resp, lat, pl);
    check("pulse_val", pl, 32'h3);
    check("pulse_resp", resp, 2'b00);
    @(negedge clk);
    check("pulse_clr", pulse_out, 32'h0);
    axi_write(8'h10, 32'hFF00FF00, 4'b0010, resp, lat, pl);
    check("pulse_strb", pl, 32'h0000FF00);
    axi_read(8'h10, rd, resp);
    check("pulse_rd", {resp, rd}, {2'b00, 32'h0});

    // Decode errors
    axi_read(8'h40, rd, resp);
    check("dec_rd40", {resp, rd}, {2'b11, 32'h0});
    axi_read(8'h14, rd, resp);
    check("dec_rd14", resp, 2'b11);
    axi_write(8'h20, 32'hFFFFFFFF, 4'hF, resp, lat, pl);
    check("dec_wr", resp, 2'b11);
    check("dec_out", gpio_out, 64'hDEADBEEF_11BB33DD);

    // Backpressure: second pair waits for the B handshake
    bus.bready = 1'b0;
    @(posedge clk); #1;
    bus.awaddr = 8'h00; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
    @(posedge clk); #1;
    bus.awaddr = 8'h04; bus.wdata = 32'h55;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.bvalid || bus.awready) seen = 1'b1;
    end
    check("bp_hold", {seen, gpio_out[31:0]}, {1'b0, 32'h1});
    @(posedge clk); #1;
    bus.bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
    check("bp_second_ready", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("bp_second", {bus.bvalid, gpio_out}, {1'b1, 64'h00000055_00000001});
    @(posedge clk); #1;

    // AW without W is never accepted
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.awready || bus.wready) seen = 1'b1;
    end
    check("aw_only", seen, 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;

    // Reset during W_ACK drops the write silently
    @(posedge clk); #1;
    bus.awaddr = 8'h04; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
    resetn = 1'b0;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.bvalid) seen = 1'b1;
    end
    check("rst_mid_b", seen, 0);
    check("rst_mid_out", gpio_out, 64'h00000005_00000005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
